balls_collision_scanner: RTL

BALLS_COLLISION_SCANNER -- requirements
Module: balls_collision_scanner

---
 rtl/balls_collision_scanner_pkg.sv | 44 ++++
 rtl/balls_collision_scanner_pair_check.sv | 43 ++++
 rtl/balls_collision_scanner.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/balls_collision_scanner_pkg.sv
// Shared definitions for the ball collision scanner.
// Holds the default ball count, the ball ID width, the squared contact
// distance, the scanner state enum, and the pair-index to (i,j) lookup.
package balls_collision_scanner_pkg;

    localparam int unsigned NUM_BALLS                = 2;
    localparam int unsigned ID_W                     = 4;
    localparam int unsigned MAX_BALLS                = 1 << ID_W;
    localparam int unsigned SQUARE_BALLS_CENTER_DIST = 1024;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } scan_state_t;

    typedef struct packed {
        logic [ID_W-1:0] j;
        logic [ID_W-1:0] i;
    } pair_t;

    // Lexicographic (i<j) enumeration of ball pairs for balls 0..nb.
    // Returns (0,0) for an index past the last pair.
    function automatic pair_t pair_of(input int unsigned idx, input int unsigned nb);
        pair_t       p;
        int unsigned k;
        p = '0;
        k = 0;
        for (int unsigned i = 0; i < MAX_BALLS; i++) begin
            for (int unsigned j = 1; j < MAX_BALLS; j++) begin
                if (i < j && j <= nb) begin
                    if (k == idx) begin
                        p.i = i[ID_W-1:0];
                        p.j = j[ID_W-1:0];
                    end
                    k++;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/balls_collision_scanner_pair_check.sv
// ball_pair_overlap_check: combinational overlap/approach test for one pair.
// Ports:
//   xi,yi,vxi,vyi  position and speed of the lower-ID ball (signed 11 bit)
//   xj,yj,vxj,vyj  position and speed of the higher-ID ball (signed 11 bit)
//   overlap        squared center distance strictly below the threshold
//   approach       relative velocity points the balls toward each other
module ball_pair_overlap_check #(
    parameter int unsigned SQUARE_BALLS_CENTER_DIST = balls_collision_scanner_pkg::SQUARE_BALLS_CENTER_DIST
) (
    input  logic signed [10:0] xi,
    input  logic signed [10:0] yi,
    input  logic signed [10:0] vxi,
    input  logic signed [10:0] vyi,
    input  logic signed [10:0] xj,
    input  logic signed [10:0] yj,
    input  logic signed [10:0] vxj,
    input  logic signed [10:0] vyj,
    output logic               overlap,
    output logic               approach
);

    logic signed [11:0] dx, dy, dvx, dvy;
    logic signed [23:0] dx2, dy2, pvx, pvy;
    logic        [23:0] d2;
    logic signed [25:0] dot;

    // Widths are chosen so no intermediate can wrap for any 11-bit input.
    always_comb begin
        dx       = $signed({xj[10], xj}) - $signed({xi[10], xi});
        dy       = $signed({yj[10], yj}) - $signed({yi[10], yi});
        dvx      = $signed({vxi[10], vxi}) - $signed({vxj[10], vxj});
        dvy      = $signed({vyi[10], vyi}) - $signed({vyj[10], vyj});
        dx2      = dx * dx;
        dy2      = dy * dy;
        d2       = $unsigned(dx2) + $unsigned(dy2);
        overlap  = d2 < 24'(SQUARE_BALLS_CENTER_DIST);
        pvx      = dvx * dx;
        pvy      = dvy * dy;
        dot      = $signed({{2{pvx[23]}}, pvx}) + $signed({{2{pvy[23]}}, pvy});
        approach = dot > 26'sd0;
    end

endmodule

// File: rtl/balls_collision_scanner.sv
// balls_collision_scanner: per-frame scan of all ball pairs for new contacts.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   startOfFrame         strobe that snapshots the inputs and starts a scan
//   topLeftX/Y_VEC_in    ball positions (one signed 11-bit entry per ball)
//   Xspeed/Yspeed_VEC_in ball speeds
//   balls_collide        bits i and j set while a pair is emitted
//   Balls_col_ID         {higher ID, lower ID} of the last emitted pair
//   col_valid            one-cycle strobe marking an emitted pair
//   scan_done            one-cycle strobe at the end of a scan
//   frame_overrun        strobe one cycle after a start request while busy
module balls_collision_scanner #(
    parameter int unsigned NUM_BALLS                = balls_collision_scanner_pkg::NUM_BALLS,
    parameter int unsigned SQUARE_BALLS_CENTER_DIST = balls_collision_scanner_pkg::SQUARE_BALLS_CENTER_DIST
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                startOfFrame,
    input  logic signed [NUM_BALLS:0][10:0]                     topLeftX_VEC_in,
    input  logic signed [NUM_BALLS:0][10:0]                     topLeftY_VEC_in,
    input  logic signed [NUM_BALLS:0][10:0]                     Xspeed_VEC_in,
    input  logic signed [NUM_BALLS:0][10:0]                     Yspeed_VEC_in,
    output logic        [NUM_BALLS:0]                           balls_collide,
    output logic        [1:0][balls_collision_scanner_pkg::ID_W-1:0] Balls_col_ID,
    output logic                                                col_valid,
    output logic                                                scan_done,
    output logic                                                frame_overrun
);

    import balls_collision_scanner_pkg::*;

    localparam int unsigned NUM_PAIRS = (NUM_BALLS + 1) * NUM_BALLS / 2;
    localparam int unsigned PW        = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int unsigned IW        = $clog2(NUM_BALLS + 1);

    scan_state_t state_q, state_d;

    logic [PW-1:0]                pair_q, pair_d;
    logic [NUM_PAIRS-1:0]         lock_q, lock_d;
    logic [NUM_BALLS:0][10:0]     x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
    logic [1:0][ID_W-1:0]         id_q, id_d;
    logic                         overrun_q, overrun_d;

    pair_t           pair;
    logic [IW-1:0]   ii, jj;
    logic            overlap, approach, hit, last_pair;

    always_comb begin
        pair      = pair_of(32'(pair_q), NUM_BALLS);
        ii        = pair.i[IW-1:0];
        jj        = pair.j[IW-1:0];
        last_pair = (pair_q == PW'(NUM_PAIRS - 1));
        hit       = overlap && approach && !lock_q[pair_q];
    end

    ball_pair_overlap_check #(
        .SQUARE_BALLS_CENTER_DIST(SQUARE_BALLS_CENTER_DIST)
    ) u_pair_check (
        .xi       (x_q[ii]),
        .yi       (y_q[ii]),
        .vxi      (vx_q[ii]),
        .vyi      (vy_q[ii]),
        .xj       (x_q[jj]),
        .yj       (y_q[jj]),
        .vxj      (vx_q[jj]),
        .vyj      (vy_q[jj]),
        .overlap  (overlap),
        .approach (approach)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startOfFrame) state_d = SCAN;
            SCAN:    if (hit) state_d = EMIT;
                     else if (last_pair) state_d = DONE;
            EMIT:    state_d = last_pair ? DONE : SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        col_valid     = (state_q == EMIT);
        scan_done     = (state_q == DONE);
        frame_overrun = overrun_q;
        Balls_col_ID  = id_q;
        balls_collide = '0;
        if (state_q == EMIT) begin
            balls_collide[ii] = 1'b1;
            balls_collide[jj] = 1'b1;
        end
    end

    // Datapath next values: snapshot, pair walk, lock bits, emitted IDs.
    // The pair index holds through SCAN->EMIT so EMIT still addresses the hit pair.
    always_comb begin
        pair_d    = pair_q;
        lock_d    = lock_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        id_d      = id_q;
        overrun_d = startOfFrame && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (startOfFrame) begin
                    x_d    = topLeftX_VEC_in;
                    y_d    = topLeftY_VEC_in;
                    vx_d   = Xspeed_VEC_in;
                    vy_d   = Yspeed_VEC_in;
                    pair_d = '0;
                end
            end
            SCAN: begin
                if (!overlap) lock_d[pair_q] = 1'b0;
                if (hit) begin
                    id_d[0] = pair.i;
                    id_d[1] = pair.j;
                end else if (!last_pair) begin
                    pair_d = pair_q + PW'(1);
                end
            end
            EMIT: begin
                lock_d[pair_q] = 1'b1;
                if (!last_pair) pair_d = pair_q + PW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pair_q    <= '0;
            lock_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            id_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            pair_q    <= pair_d;
            lock_q    <= lock_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            id_q      <= id_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
